fwd_hazard_ctrl: RTL and testbench

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

---
 rtl/fwd_pkg.sv | 27 ++
 rtl/fwd_hazard_ctrl_if.sv | 37 +++
 rtl/fwd_src_cmp.sv | 40 ++++
 rtl/fwd_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// Shared encodings and default parameter values for the forwarding / hazard
// controller and its per-source comparator.
package fwd_pkg;

    localparam int NSRC_DEF     = 2;
    localparam int RW_DEF       = 4;
    localparam int FWD_EN_DEF   = 1;
    localparam int ZERO_REG_DEF = 1;
    localparam int CNT_W_DEF    = 16;

    // EX operand select, one 2-bit field per source operand
    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    // Positions of the shadow pipeline entries
    typedef enum int {
        STG_EX  = 0,
        STG_MEM = 1,
        STG_WB  = 2
    } stage_e;

    localparam int STG_NUM = 3;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side request and control-side response bundle of fwd_hazard_ctrl.
// The pipeline front end is the master; the hazard controller is the slave.
interface fwd_hazard_ctrl_if
    import fwd_pkg::*;
#(
    parameter int NSRC  = NSRC_DEF,
    parameter int RW    = RW_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic                 id_valid;
    logic [NSRC*RW-1:0]   id_rs;
    logic [NSRC-1:0]      id_src_used;
    logic [RW-1:0]        id_rd;
    logic                 id_regwrite;
    logic                 id_memread;
    logic                 id_memwrite;
    logic                 mem_busy;
    logic                 flush;

    logic                 stall_id;
    logic [NSRC*2-1:0]    fwd_sel;
    logic                 mm_fwd;
    logic [CNT_W-1:0]     stall_cnt;

    modport master (
        output id_valid, id_rs, id_src_used, id_rd, id_regwrite, id_memread,
               id_memwrite, mem_busy, flush,
        input  stall_id, fwd_sel, mm_fwd, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_src_used, id_rd, id_regwrite, id_memread,
               id_memwrite, mem_busy, flush,
        output stall_id, fwd_sel, mm_fwd, stall_cnt
    );

endinterface

// File: rtl/fwd_src_cmp.sv
// Compares one decode source index against the EX and MEM shadow entries and
// picks that source's forwarding select (EX has priority over MEM).
module fwd_src_cmp
    import fwd_pkg::*;
#(
    parameter int RW       = RW_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic [RW-1:0] rs,
    input  logic          used,
    input  logic          ex_valid,
    input  logic          ex_regwrite,
    input  logic [RW-1:0] ex_rd,
    input  logic          mem_valid,
    input  logic          mem_regwrite,
    input  logic [RW-1:0] mem_rd,
    output logic          hit_ex,
    output logic          hit_mem,
    output fwd_sel_e      sel
);

    logic rs_live;

    // Register 0 is hardwired, so it never carries a producer when ZERO_REG is set
    assign rs_live = used && ((ZERO_REG == 0) || (rs != '0));

    assign hit_ex  = rs_live && ex_valid  && ex_regwrite  && (ex_rd  == rs);
    assign hit_mem = rs_live && mem_valid && mem_regwrite && (mem_rd == rs);

    // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        sel = FWD_NONE;
        if (hit_ex) begin
            sel = FWD_EXMEM;
        end else if (hit_mem) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: shadows the EX/MEM/WB occupants,
// raises stall_id, and registers the EX operand and MEM store-data selects.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int NSRC     = NSRC_DEF,
    parameter int RW       = RW_DEF,
    parameter int FWD_EN   = FWD_EN_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input logic              clk,
    input logic              rst,
    fwd_hazard_ctrl_if.slave bus
);

    // Source 1 carries ALU B and the store data
    localparam int SRC1 = (NSRC > 1) ? 1 : 0;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic [RW-1:0] src1;
    } entry_t;

    entry_t            stage_q [STG_NUM];
    entry_t            id_entry;
    logic [NSRC-1:0]   hit_ex;
    logic [NSRC-1:0]   hit_mem;
    fwd_sel_e          src_sel [NSRC];
    logic [NSRC*2-1:0] fwd_sel_d;
    logic [NSRC*2-1:0] fwd_sel_q;
    logic              mm_fwd_d;
    logic              mm_fwd_q;
    logic              stall_id;
    logic              flush_pend_q;
    logic              load_bubble;
    logic [CNT_W-1:0]  stall_cnt_q;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_src_cmp #(
            .RW       (RW),
            .ZERO_REG (ZERO_REG)
        ) u_cmp (
            .rs           (bus.id_rs[i*RW +: RW]),
            .used         (bus.id_src_used[i]),
            .ex_valid     (stage_q[STG_EX].valid),
            .ex_regwrite  (stage_q[STG_EX].regwrite),
            .ex_rd        (stage_q[STG_EX].rd),
            .mem_valid    (stage_q[STG_MEM].valid),
            .mem_regwrite (stage_q[STG_MEM].regwrite),
            .mem_rd       (stage_q[STG_MEM].rd),
            .hit_ex       (hit_ex[i]),
            .hit_mem      (hit_mem[i]),
            .sel          (src_sel[i])
        );
        assign fwd_sel_d[i*2 +: 2] = src_sel[i];
    end

    // Forwarding only has to wait out a load in EX; stall-only mode waits for
    // any producer still ahead of the register file write.
    always_comb begin
        stall_id = 1'b0;
        if (bus.id_valid) begin
            if (FWD_EN != 0) begin
                stall_id = (|hit_ex) && stage_q[STG_EX].memread;
            end else begin
                stall_id = (|hit_ex) || (|hit_mem);
            end
        end
    end

    always_comb begin
        id_entry          = '0;
        id_entry.valid    = 1'b1;
        id_entry.rd       = bus.id_rd;
        id_entry.regwrite = bus.id_regwrite;
        id_entry.memread  = bus.id_memread;
        id_entry.memwrite = bus.id_memwrite;
        id_entry.src1     = bus.id_rs[SRC1*RW +: RW];
    end

    assign load_bubble = stall_id || bus.flush || flush_pend_q || !bus.id_valid;

    // Store in EX whose data register is being produced by the instruction in MEM
    assign mm_fwd_d = (FWD_EN != 0)
                   && stage_q[STG_EX].valid  && stage_q[STG_EX].memwrite
                   && stage_q[STG_MEM].valid && stage_q[STG_MEM].regwrite
                   && (stage_q[STG_MEM].rd == stage_q[STG_EX].src1)
                   && ((ZERO_REG == 0) || (stage_q[STG_MEM].rd != '0));

    // NOTE: the shadow entries are few and their valid bits gate every match, so they are cleared on reset like any other state.
    // NOTE: sequential state uses non-blocking assignments so every entry shifts from its pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STG_NUM; s++) begin
                stage_q[s] <= '0;
            end
            fwd_sel_q    <= '0;
            mm_fwd_q     <= 1'b0;
            stall_cnt_q  <= '0;
            flush_pend_q <= 1'b0;
        end else if (bus.mem_busy) begin
            if (bus.flush) begin
                flush_pend_q <= 1'b1;
            end
        end else begin
            stage_q[STG_WB]  <= stage_q[STG_MEM];
            stage_q[STG_MEM] <= stage_q[STG_EX];
            stage_q[STG_EX]  <= load_bubble ? '0 : id_entry;
            fwd_sel_q        <= (load_bubble || (FWD_EN == 0)) ? '0 : fwd_sel_d;
            mm_fwd_q         <= mm_fwd_d;
            flush_pend_q     <= 1'b0;
            if (stall_id && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign bus.stall_id  = stall_id;
    assign bus.fwd_sel   = fwd_sel_q;
    assign bus.mm_fwd    = mm_fwd_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: a forwarding instance and a stall-only instance with a
// 3-bit counter share one stimulus stream and are checked against an instruction-level model.
module tb_fwd_hazard_ctrl;
    import fwd_pkg::*;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       wr;
        logic       ld;
        logic       st;
        logic [3:0] rs0;
        logic [3:0] rs1;
        logic [1:0] used;
    } inst_t;

    localparam inst_t NOP = '0;

    logic clk;
    logic rst;

    fwd_hazard_ctrl_if #(.NSRC(2), .RW(4), .CNT_W(16)) bus_a ();
    fwd_hazard_ctrl_if #(.NSRC(2), .RW(4), .CNT_W(3))  bus_b ();

    assign bus_b.id_valid    = bus_a.id_valid;
    assign bus_b.id_rs       = bus_a.id_rs;
    assign bus_b.id_src_used = bus_a.id_src_used;
    assign bus_b.id_rd       = bus_a.id_rd;
    assign bus_b.id_regwrite = bus_a.id_regwrite;
    assign bus_b.id_memread  = bus_a.id_memread;
    assign bus_b.id_memwrite = bus_a.id_memwrite;
    assign bus_b.mem_busy    = bus_a.mem_busy;
    assign bus_b.flush       = bus_a.flush;

    fwd_hazard_ctrl #(.NSRC(2), .RW(4), .FWD_EN(1), .ZERO_REG(1), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    fwd_hazard_ctrl #(.NSRC(2), .RW(4), .FWD_EN(0), .ZERO_REG(1), .CNT_W(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model state per mode: index 0 = forwarding, 1 = stall-only
    bit    fen  [2] = '{1'b1, 1'b0};
    int    cmax [2] = '{65535, 7};
    inst_t ex_m [2];
    inst_t mem_m[2];
    bit    pend_m[2];
    logic [3:0] exp_sel[2];
    bit    exp_mm[2];
    int    exp_cnt[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic inst_t mk(input int rd, input bit wr, input bit ld, input bit st,
                                 input int rs0, input int rs1, input logic [1:0] used);
        inst_t r;
        r.valid = 1'b1;
        r.rd    = 4'(rd);
        r.wr    = wr;
        r.ld    = ld;
        r.st    = st;
        r.rs0   = 4'(rs0);
        r.rs1   = 4'(rs1);
        r.used  = used;
        return r;
    endfunction

    // An older instruction supplies register r to a reader that actually uses it
    function automatic bit produces(input inst_t older, input logic [3:0] r, input bit used);
        return used && older.valid && older.wr && (older.rd == r) && (r != 4'd0);
    endfunction

    function automatic bit exp_stall(input int m, input inst_t id);
        bit s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            logic [3:0] r = (i == 0) ? id.rs0 : id.rs1;
            bit u = id.used[i];
            if (fen[m]) s |= produces(ex_m[m], r, u) && ex_m[m].ld;
            else        s |= produces(ex_m[m], r, u) || produces(mem_m[m], r, u);
        end
        return id.valid && s;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            ex_m[m]    = NOP;
            mem_m[m]   = NOP;
            pend_m[m]  = 1'b0;
            exp_sel[m] = 4'd0;
            exp_mm[m]  = 1'b0;
            exp_cnt[m] = 0;
        end
    endtask

    task automatic model_adv(input int m, input inst_t id, input bit busy, input bit fl, input bit stall);
        bit kill;
        logic [3:0] sel;
        if (busy) begin
            pend_m[m] = pend_m[m] | fl;
            return;
        end
        kill = stall || fl || pend_m[m] || !id.valid;
        sel  = 4'd0;
        if (!kill && fen[m]) begin
            for (int i = 0; i < 2; i++) begin
                logic [3:0] r = (i == 0) ? id.rs0 : id.rs1;
                if (produces(ex_m[m], r, id.used[i]))       sel[i*2 +: 2] = 2'b01;
                else if (produces(mem_m[m], r, id.used[i])) sel[i*2 +: 2] = 2'b10;
            end
        end
        exp_sel[m] = sel;
        exp_mm[m]  = fen[m] && ex_m[m].valid && ex_m[m].st && mem_m[m].valid && mem_m[m].wr
                     && (mem_m[m].rd == ex_m[m].rs1) && (mem_m[m].rd != 4'd0);
        if (stall && exp_cnt[m] < cmax[m]) exp_cnt[m]++;
        mem_m[m]  = ex_m[m];
        ex_m[m]   = kill ? NOP : id;
        pend_m[m] = 1'b0;
    endtask

    task automatic drive(input inst_t ins, input bit busy, input bit fl);
        bus_a.id_valid    = ins.valid;
        bus_a.id_rs       = {ins.rs1, ins.rs0};
        bus_a.id_src_used = ins.used;
        bus_a.id_rd       = ins.rd;
        bus_a.id_regwrite = ins.wr;
        bus_a.id_memread  = ins.ld;
        bus_a.id_memwrite = ins.st;
        bus_a.mem_busy    = busy;
        bus_a.flush       = fl;
    endtask

    // Present one decode slot, check both instances, then advance the model across the edge
    task automatic step(input inst_t ins, input bit busy, input bit fl);
        bit s [2];
        @(negedge clk);
        drive(ins, busy, fl);
        #1;
        for (int m = 0; m < 2; m++) s[m] = exp_stall(m, ins);
        check("stall_a", bus_a.stall_id,  s[0]);
        check("sel_a",   bus_a.fwd_sel,   exp_sel[0]);
        check("mm_a",    bus_a.mm_fwd,    exp_mm[0]);
        check("cnt_a",   bus_a.stall_cnt, exp_cnt[0]);
        check("stall_b", bus_b.stall_id,  s[1]);
        check("sel_b",   bus_b.fwd_sel,   exp_sel[1]);
        check("mm_b",    bus_b.mm_fwd,    exp_mm[1]);
        check("cnt_b",   bus_b.stall_cnt, exp_cnt[1]);
        for (int m = 0; m < 2; m++) model_adv(m, ins, busy, fl, s[m]);
    endtask

    // Reset asserted mid-cycle with a live decode slot; outputs must clear at once
    task automatic pulse_reset(input inst_t ins);
        @(negedge clk);
        drive(ins, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_stall_a", bus_a.stall_id,  0);
        check("rst_sel_a",   bus_a.fwd_sel,   0);
        check("rst_mm_a",    bus_a.mm_fwd,    0);
        check("rst_cnt_a",   bus_a.stall_cnt, 0);
        check("rst_stall_b", bus_b.stall_id,  0);
        check("rst_sel_b",   bus_b.fwd_sel,   0);
        check("rst_cnt_b",   bus_b.stall_cnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        inst_t r;
        rst = 1'b1;
        drive(NOP, 1'b0, 1'b0);
        model_reset();
        pulse_reset(NOP);

        // Writer r3 then reader of r3 on source 0
        step(mk(3, 1, 0, 0, 1, 2, 2'b11), 0, 0);
        step(mk(7, 1, 0, 0, 3, 0, 2'b01), 0, 0);
        check("r3_no_stall", bus_a.stall_id, 0);
        step(NOP, 0, 0);
        check("r3_sel0_exmem", bus_a.fwd_sel[1:0], 2'b01);

        // Load r5 then a reader of r5 on source 1
        pulse_reset(mk(1, 1, 0, 0, 1, 1, 2'b11));
        step(mk(5, 1, 1, 0, 1, 0, 2'b01), 0, 0);
        step(mk(6, 1, 0, 0, 1, 5, 2'b10), 0, 0);
        check("lu_stall", bus_a.stall_id, 1);
        step(mk(6, 1, 0, 0, 1, 5, 2'b10), 0, 0);
        check("lu_stall_gone", bus_a.stall_id, 0);
        step(NOP, 0, 0);
        check("lu_sel1_memwb", bus_a.fwd_sel[3:2], 2'b10);
        check("lu_cnt", bus_a.stall_cnt, 1);

        // Independent op, writer r4, then store whose data is r4
        pulse_reset(NOP);
        step(mk(7, 1, 0, 0, 1, 1, 2'b00), 0, 0);
        step(mk(4, 1, 0, 0, 1, 1, 2'b11), 0, 0);
        step(mk(0, 0, 0, 1, 2, 4, 2'b11), 0, 0);
        step(NOP, 0, 0);
        check("st_sel", bus_a.fwd_sel, 4'b0100);
        check("st_mm_early", bus_a.mm_fwd, 0);
        step(NOP, 0, 0);
        check("st_mm", bus_a.mm_fwd, 1);

        // Register 0 as producer and consumer
        pulse_reset(NOP);
        step(mk(0, 1, 1, 0, 1, 1, 2'b00), 0, 0);
        step(mk(8, 1, 0, 0, 0, 0, 2'b11), 0, 0);
        check("r0_stall_a", bus_a.stall_id, 0);
        check("r0_stall_b", bus_b.stall_id, 0);
        step(NOP, 0, 0);
        check("r0_sel", bus_a.fwd_sel, 0);

        // Stall-only instance: writer r2 then reader r2 held in decode
        pulse_reset(NOP);
        step(mk(2, 1, 0, 0, 1, 1, 2'b00), 0, 0);
        step(mk(9, 1, 0, 0, 2, 3, 2'b01), 0, 0);
        check("so_stall1", bus_b.stall_id, 1);
        step(mk(9, 1, 0, 0, 2, 3, 2'b01), 0, 0);
        check("so_stall2", bus_b.stall_id, 1);
        step(mk(9, 1, 0, 0, 2, 3, 2'b01), 0, 0);
        check("so_stall_end", bus_b.stall_id, 0);
        step(NOP, 0, 0);
        check("so_sel", bus_b.fwd_sel, 0);
        check("so_cnt", bus_b.stall_cnt, 2);

        // Flush held across three frozen cycles, then one advance
        pulse_reset(NOP);
        step(mk(3, 1, 0, 0, 1, 1, 2'b00), 0, 0);
        step(mk(6, 1, 0, 0, 3, 0, 2'b01), 0, 0);
        r = mk(10, 1, 0, 0, 6, 0, 2'b01);
        for (int k = 0; k < 3; k++) begin
            step(r, 1, 1);
            check("busy_hold_sel", bus_a.fwd_sel, 4'b0001);
        end
        step(r, 0, 0);
        step(NOP, 0, 0);
        check("flush_bubble_sel", bus_a.fwd_sel, 0);
        step(r, 0, 0);
        pulse_reset(r);

        // Randomised traffic over a narrow register range to force frequent hazards
        for (int n = 0; n < 600; n++) begin
            r.valid = ($urandom_range(0, 9) != 0);
            r.rd    = 4'($urandom_range(0, 7));
            r.wr    = ($urandom_range(0, 3) != 0);
            r.ld    = r.wr && ($urandom_range(0, 2) == 0);
            r.st    = !r.wr && ($urandom_range(0, 1) == 0);
            r.rs0   = 4'($urandom_range(0, 7));
            r.rs1   = 4'($urandom_range(0, 7));
            r.used  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset(r);
            end else begin
                step(r, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
